xy_route_alloc: RTL
===================

Name: xy_route_alloc

Overview:
- Parametrised successor to the per-router route-compute stage for the 2x4 mesh NoC.
- Computes the dimension-ordered output port for each of NUM_IN input ports and allocates output ports with per-output round-robin arbitration.
- An output stays locked to its winner until the winner signals its tail flit.
- Sits between the input buffers and the crossbar select logic of each router.

Parameters:
X_W, 2, bits of X coordinate
Y_W, 1, bits of Y coordinate
MESH_X, 4, number of columns; valid x is 0..MESH_X-1
MESH_Y, 2, number of rows; valid y is 0..MESH_Y-1
NUM_IN, 5, number of input ports; also number of output ports (fixed 5 directions)
ROUTE_MODE, 0, 0 = XY (X first), 1 = YX (Y first)

Ports:
clk  in  1  clock
rst  in  1  asynchronous active-high reset
my_x  in  X_W  this router's x; static after reset
my_y  in  Y_W  this router's y; static after reset
in_head_vld  in  NUM_IN  per-input request; head flit present; held until grant
in_dst  in  NUM_IN*(X_W+Y_W)  per-input destination {y,x}; input i at slice i
in_tail  in  NUM_IN  per-input pulse; tail flit of the granted packet leaves this cycle
in_grant  out  NUM_IN  per-input level; input owns its routed output
in_port  out  NUM_IN*3  per-input registered route result
out_busy  out  5  per-output level; output locked
out_sel  out  5*3  per-output index of the owning input; 0 when free
dst_err  out  NUM_IN  one-cycle pulse; dst outside the mesh

Behaviour:
- Port codes: LOCAL=0, X1 (x-decreasing)=1, X2 (x-increasing)=2, Y1 (y-decreasing)=3, Y2 (y-increasing)=4. Codes 5..7 are never produced.
- Reset (async, rst=1): all outputs 0; all rr pointers 0; all route-valid flags 0. Reset mid-packet drops every lock immediately; there is no recovery of in-flight state.

Route compute (stage 1, 1-cycle latency):
- Edge N with in_head_vld[i]=1 and in_grant[i]=0 registers in_port[i] and sets rc_vld[i].
- XY mode:
  - x differs: X2 if my_x<dst_x, else X1.
  - x equal: LOCAL if y equal; Y2 if my_y<dst_y; else Y1.
- YX mode: same rule with the two dimensions swapped.
- Unsigned compares at X_W/Y_W width.
- dst_x>=MESH_X or dst_y>=MESH_Y: in_port[i]=LOCAL, dst_err[i] pulses 1 cycle, rc_vld[i] stays 0 (packet is not granted; upstream drops it).
- in_head_vld[i] dropped before grant: rc_vld[i] clears at the next edge; no grant issued.

Allocation (stage 2):
- The cycle after rc_vld[i] rises, input i requests output in_port[i].
- Free output: the round-robin arbiter picks among requesters, starting at pointer p and searching p, p+1 … wrapping at NUM_IN.
- At the next edge the winner gets in_grant=1, the output gets out_busy=1 and out_sel=winner, and p becomes winner+1 mod NUM_IN.
- Best-case latency from head_vld to in_grant is 2 cycles.
- Losers keep requesting. Their in_port is not recomputed while rc_vld is held.

Release:
- in_tail[i]=1 while in_grant[i]=1 clears in_grant[i], rc_vld[i], out_busy and out_sel at the next edge.
- in_tail while not granted is ignored.
- The released output can be granted no earlier than the edge after the release edge (one idle cycle); this is intentional.

Simultaneous events:
- Tail and a new head_vld on the same input in the same cycle: release takes precedence; the new head is route-computed on the following edge.
- Several outputs can be granted on the same edge.
- An input holds at most one grant.

Test Plan:
- Route, XY, defaults: my=(x1,y0); dst {0,3}->X2, {0,0}->X1, {1,1}->Y2, {0,1}->LOCAL. Each in_port appears 1 cycle after head_vld; in_grant follows 1 cycle later.
- Route, YX mode: ROUTE_MODE=1, my=(1,0), dst {1,3} -> Y2 (not X2).
- Contention: inputs 1, 3 and 4 all request X2 at pointer 0. Grants go to 1, then 3, then 4. Each new grant arrives on the 2nd edge after the previous in_tail (the release edge, then one idle cycle). out_sel reads 1, 3, 4.
- Lock hold: input 2 granted LOCAL with a 6-cycle packet. Input 0 requesting LOCAL sees no grant until 2 cycles after in_tail[2]. out_busy[0] stays 1 throughout.
- Out-of-range: dst_x=3 with MESH_X=3. dst_err pulses 1 cycle and in_grant never asserts.
- Reset mid-packet: raise rst while 3 grants are active. All outputs are 0 asynchronously. After rst falls, a fresh request is granted 2 cycles after head_vld.

Source files
------------

// File: rtl/xy_route_alloc.sv
// -----------------------------------------------------------------------------
// xy_route_alloc
//   Route-compute and output-allocation stage of one router in the 2x4 mesh
//   NoC. Each input's head flit is routed with dimension-ordered routing (XY or
//   YX), then every output runs its own round-robin arbiter over the inputs
//   that routed to it. A granted output stays locked to its owner until the
//   owner's tail flit leaves.
//
// Ports
//   clk, rst      clock, asynchronous active-high reset
//   my_x, my_y    this router's coordinates (static after reset)
//   in_head_vld   per input: head flit present, held until granted
//   in_dst        per input: destination {y,x}, input i at slice i
//   in_tail       per input: tail flit of the granted packet leaves this cycle
//   in_grant      per input: input owns its routed output
//   in_port       per input: registered route result (3-bit port code)
//   out_busy      per output: output locked
//   out_sel       per output: index of the owning input, 0 when free
//   dst_err       per input: one-cycle pulse, destination outside the mesh
//
// Port codes: 0 LOCAL, 1 X-decreasing, 2 X-increasing, 3 Y-decreasing,
//             4 Y-increasing.
// -----------------------------------------------------------------------------
module xy_route_alloc #(
  parameter int X_W        = 2,
  parameter int Y_W        = 1,
  parameter int MESH_X     = 4,
  parameter int MESH_Y     = 2,
  parameter int NUM_IN     = 5,
  parameter int ROUTE_MODE = 0
) (
  input  logic                        clk,
  input  logic                        rst,
  input  logic [X_W-1:0]              my_x,
  input  logic [Y_W-1:0]              my_y,
  input  logic [NUM_IN-1:0]           in_head_vld,
  input  logic [NUM_IN*(X_W+Y_W)-1:0] in_dst,
  input  logic [NUM_IN-1:0]           in_tail,
  output logic [NUM_IN-1:0]           in_grant,
  output logic [NUM_IN*3-1:0]         in_port,
  output logic [4:0]                  out_busy,
  output logic [14:0]                 out_sel,
  output logic [NUM_IN-1:0]           dst_err
);

  localparam int D_W     = X_W + Y_W;
  localparam int NUM_OUT = 5;
  localparam int IW      = (NUM_IN > 1) ? $clog2(NUM_IN) : 1;

  localparam logic [2:0] P_LOCAL = 3'd0;
  localparam logic [2:0] P_X1    = 3'd1;
  localparam logic [2:0] P_X2    = 3'd2;
  localparam logic [2:0] P_Y1    = 3'd3;
  localparam logic [2:0] P_Y2    = 3'd4;

  // Dimension-ordered route. The first dimension that differs decides the
  // direction; only when both match does the packet eject locally.
  function automatic logic [2:0] route_port(
    input logic [X_W-1:0] cx,
    input logic [Y_W-1:0] cy,
    input logic [X_W-1:0] dx,
    input logic [Y_W-1:0] dy
  );
    logic [2:0] xp;
    logic [2:0] yp;
    logic [2:0] res;
    xp = (cx < dx) ? P_X2 : P_X1;
    yp = (cy < dy) ? P_Y2 : P_Y1;
    if (ROUTE_MODE == 0) begin
      if (dx != cx)      res = xp;
      else if (dy != cy) res = yp;
      else               res = P_LOCAL;
    end else begin
      if (dy != cy)      res = yp;
      else if (dx != cx) res = xp;
      else               res = P_LOCAL;
    end
    return res;
  endfunction

  function automatic logic dst_outside(
    input logic [X_W-1:0] dx,
    input logic [Y_W-1:0] dy
  );
    return (int'(dx) >= MESH_X) || (int'(dy) >= MESH_Y);
  endfunction

  // Stage 1 state: route result per input
  logic [NUM_IN-1:0]  rc_vld_p1;
  logic [2:0]         port_p1 [NUM_IN];
  logic [NUM_IN-1:0]  err_p1;

  // Stage 2 state: grants, output locks, round-robin pointers
  logic [NUM_IN-1:0]  grant_p2;
  logic [NUM_OUT-1:0] busy_p2;
  logic [2:0]         sel_p2 [NUM_OUT];
  logic [IW-1:0]      ptr_p2 [NUM_OUT];

  // Next-state values
  logic [NUM_IN-1:0]  rc_vld_nx;
  logic [2:0]         port_nx [NUM_IN];
  logic [NUM_IN-1:0]  err_nx;
  logic [NUM_IN-1:0]  grant_nx;
  logic [NUM_OUT-1:0] busy_nx;
  logic [2:0]         sel_nx [NUM_OUT];
  logic [IW-1:0]      ptr_nx [NUM_OUT];

  // Working variables
  logic [X_W-1:0]     dx;
  logic [Y_W-1:0]     dy;
  logic               rel;
  logic [NUM_IN-1:0]  req;
  logic               found;
  logic [IW-1:0]      win;
  logic [IW-1:0]      cand;
  int                 pos;

  always_comb begin
    rc_vld_nx = rc_vld_p1;
    port_nx   = port_p1;
    err_nx    = '0;
    grant_nx  = grant_p2;
    busy_nx   = busy_p2;
    sel_nx    = sel_p2;
    ptr_nx    = ptr_p2;
    dx        = '0;
    dy        = '0;
    rel       = 1'b0;
    req       = '0;
    found     = 1'b0;
    win       = '0;
    cand      = '0;
    pos       = 0;

    // ---- stage 1: route compute / release ----
    for (int i = 0; i < NUM_IN; i++) begin
      dx  = in_dst[i*D_W +: X_W];
      dy  = in_dst[i*D_W+X_W +: Y_W];
      rel = in_tail[i] & grant_p2[i];
      if (rel) begin
        // Release wins over a same-cycle head; that head is routed next edge.
        rc_vld_nx[i]          = 1'b0;
        grant_nx[i]           = 1'b0;
        busy_nx[port_p1[i]]   = 1'b0;
        sel_nx[port_p1[i]]    = 3'd0;
      end else if (!grant_p2[i]) begin
        if (!in_head_vld[i]) begin
          rc_vld_nx[i] = 1'b0;
        end else if (!rc_vld_p1[i]) begin
          // Route is held while waiting, so only compute on a fresh head.
          if (dst_outside(dx, dy)) begin
            port_nx[i] = P_LOCAL;
            err_nx[i]  = 1'b1;
          end else begin
            port_nx[i]   = route_port(my_x, my_y, dx, dy);
            rc_vld_nx[i] = 1'b1;
          end
        end
      end
    end

    // ---- stage 2: per-output round-robin allocation ----
    for (int o = 0; o < NUM_OUT; o++) begin
      for (int i = 0; i < NUM_IN; i++) begin
        req[i] = rc_vld_p1[i] & in_head_vld[i] & ~grant_p2[i] &
                 (port_p1[i] == 3'(o));
      end
      found = 1'b0;
      win   = '0;
      for (int k = 0; k < NUM_IN; k++) begin
        pos = int'(ptr_p2[o]) + k;
        if (pos >= NUM_IN) pos = pos - NUM_IN;
        cand = IW'(pos);
        if (!found && req[cand]) begin
          found = 1'b1;
          win   = cand;
        end
      end
      // A just-released output is still busy this cycle, giving one idle cycle.
      if (!busy_p2[o] && found) begin
        grant_nx[win] = 1'b1;
        busy_nx[o]    = 1'b1;
        sel_nx[o]     = 3'(win);
        ptr_nx[o]     = (int'(win) + 1 >= NUM_IN) ? '0 : IW'(int'(win) + 1);
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      rc_vld_p1 <= '0;
      err_p1    <= '0;
      grant_p2  <= '0;
      busy_p2   <= '0;
      for (int i = 0; i < NUM_IN; i++) port_p1[i] <= P_LOCAL;
      for (int o = 0; o < NUM_OUT; o++) begin
        sel_p2[o] <= 3'd0;
        ptr_p2[o] <= '0;
      end
    end else begin
      rc_vld_p1 <= rc_vld_nx;
      err_p1    <= err_nx;
      grant_p2  <= grant_nx;
      busy_p2   <= busy_nx;
      port_p1   <= port_nx;
      sel_p2    <= sel_nx;
      ptr_p2    <= ptr_nx;
    end
  end

  always_comb begin
    in_port = '0;
    out_sel = '0;
    for (int i = 0; i < NUM_IN; i++) in_port[i*3 +: 3] = port_p1[i];
    for (int o = 0; o < NUM_OUT; o++) out_sel[o*3 +: 3] = sel_p2[o];
  end

  assign in_grant = grant_p2;
  assign out_busy = busy_p2;
  assign dst_err  = err_p1;

endmodule
